// File: rtl/wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_master_pkg
// Description : Shared types and constants for the Wishbone initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_master_pkg;

    localparam int C_WB_DATA_WIDTH = 32;

    // Value presented on the client read bus whenever no valid read data exists
    localparam logic [C_WB_DATA_WIDTH-1:0] C_IDLE_READ_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        STATE_IDLE     = 2'd0,
        STATE_REQUEST  = 2'd1,
        STATE_WAIT_ACK = 2'd2,
        STATE_FINISH   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_master_interface_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_counter
// Description : Cycle counter that flags the cycle in which it reaches limit.
//               A limit of zero never expires.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear has priority over counting
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + C_ONE;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged on the edge where the count would become equal to limit
    assign expired = enable && !clear && (limit != '0) && (count_q == (limit - C_ONE));

endmodule
`default_nettype wire

// File: rtl/wb_master_interface.sv
`default_nettype none
// ============================================================================
// Module      : wb_master_interface
// Description : Wishbone pipelined initiator issuing single 32-bit reads and
//               writes for a level-held client request, with response timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_master_interface
    import wb_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_n_i,
    input  logic [ADDR_WIDTH-1:0]      coreAddress,
    input  logic [3:0]                 coreByteSelect,
    input  logic                       coreWriteEnable,
    input  logic                       coreReadEnable,
    input  logic [C_WB_DATA_WIDTH-1:0] coreDataWrite,
    output logic [C_WB_DATA_WIDTH-1:0] coreDataRead,
    output logic                       coreBusy,
    output logic                       coreError,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [3:0]                 wb_sel_o,
    output logic [ADDR_WIDTH-1:0]      wb_adr_o,
    output logic [C_WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic [C_WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic                       wb_ack_i,
    input  logic                       wb_stall_i,
    input  logic                       wb_error_i
);

    localparam logic [TIMEOUT_WIDTH-1:0] C_TIMEOUT_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    state_t                       state_q,  state_d;
    logic                         cyc_q,    cyc_d;
    logic                         stb_q,    stb_d;
    logic                         we_q,     we_d;
    logic [3:0]                   sel_q,    sel_d;
    logic [ADDR_WIDTH-1:0]        adr_q,    adr_d;
    logic [C_WB_DATA_WIDTH-1:0]   wdata_q,  wdata_d;
    logic [C_WB_DATA_WIDTH-1:0]   rdata_q,  rdata_d;
    logic                         err_q,    err_d;

    logic w_request;
    logic w_response;
    logic w_expired;
    logic w_counting;

    assign w_request  = coreWriteEnable || coreReadEnable;
    assign w_counting = (state_q == STATE_REQUEST) || (state_q == STATE_WAIT_ACK);

    // A response only counts once the strobe has been (or is being) accepted
    assign w_response = (wb_ack_i || wb_error_i) &&
                        ((state_q == STATE_WAIT_ACK) ||
                         ((state_q == STATE_REQUEST) && !wb_stall_i));

    wb_timeout_counter #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_n_i),
        .clear   (state_q == STATE_IDLE),
        .enable  (w_counting),
        .limit   (C_TIMEOUT_LIMIT),
        .expired (w_expired)
    );

    // Next-state and next-output computation for the transaction sequencer
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            STATE_IDLE: begin
                if (w_request) begin
                    adr_d   = coreAddress;
                    sel_d   = coreByteSelect;
                    we_d    = coreWriteEnable;
                    wdata_d = coreWriteEnable ? coreDataWrite : '0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = STATE_REQUEST;
                end
            end
            STATE_REQUEST, STATE_WAIT_ACK: begin
                if ((state_q == STATE_REQUEST) && !wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = STATE_WAIT_ACK;
                end
                // A real response beats a timeout expiring on the same edge
                if (w_response) begin
                    cyc_d   = 1'b0;
                    state_d = STATE_FINISH;
                    if (wb_error_i) begin
                        err_d   = 1'b1;
                        rdata_d = C_IDLE_READ_VALUE;
                    end else if (!we_q) begin
                        rdata_d = wb_data_i;
                    end
                end else if (w_expired) begin
                    stb_d   = 1'b0;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    rdata_d = C_IDLE_READ_VALUE;
                    state_d = STATE_FINISH;
                end
            end
            STATE_FINISH: begin
                rdata_d = C_IDLE_READ_VALUE;
                err_d   = 1'b0;
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // State and registered bus/client outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= STATE_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= C_IDLE_READ_VALUE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Busy follows the raw request in IDLE and drops only for the FINISH cycle
    assign coreBusy     = (state_q == STATE_IDLE) ? w_request : (state_q != STATE_FINISH);
    assign coreDataRead = rdata_q;
    assign coreError    = err_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_we_o      = we_q;
    assign wb_sel_o     = sel_q;
    assign wb_adr_o     = adr_q;
    assign wb_data_o    = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_master_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_master_interface
// Description : Self-checking bench for the Wishbone initiator; a per-access
//               timing model derives every expected bus and client value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_interface;

    localparam int          TO   = 8;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] coreAddress = '0;
    logic [3:0]  coreByteSelect = '0;
    logic        coreWriteEnable = 1'b0;
    logic        coreReadEnable = 1'b0;
    logic [31:0] coreDataWrite = '0;
    logic [31:0] coreDataRead;
    logic        coreBusy;
    logic        coreError;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [23:0] wb_adr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_stall_i = 1'b0;
    logic        wb_error_i = 1'b0;

    int  tests = 0;
    int  fails = 0;
    time t_start;
    time t_first;

    always #5 clk = ~clk;

    wb_master_interface #(
        .ADDR_WIDTH     (24),
        .TIMEOUT_CYCLES (TO),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_n_i      (rst_n),
        .coreAddress     (coreAddress),
        .coreByteSelect  (coreByteSelect),
        .coreWriteEnable (coreWriteEnable),
        .coreReadEnable  (coreReadEnable),
        .coreDataWrite   (coreDataWrite),
        .coreDataRead    (coreDataRead),
        .coreBusy        (coreBusy),
        .coreError       (coreError),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_sel_o        (wb_sel_o),
        .wb_adr_o        (wb_adr_o),
        .wb_data_o       (wb_data_o),
        .wb_data_i       (wb_data_i),
        .wb_ack_i        (wb_ack_i),
        .wb_stall_i      (wb_stall_i),
        .wb_error_i      (wb_error_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One client access against a scripted slave.
    //  s     : edges the slave stalls the strobe (acceptance on edge 1+s)
    //  d     : edges after acceptance until the response (0 = same edge)
    //  spur  : slave pulses ack while stalling (must be ignored)
    //  hold  : client keeps its request through FINISH
    task automatic access(input bit wr, input bit rd, input logic [23:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata,
                          input int s, input int d, input bit is_err,
                          input logic [31:0] rdata, input bit spur, input bit hold);
        int          a;
        int          r;
        int          e;
        bit          exp_err;
        logic [31:0] exp_rd;
        a = 1 + s;
        r = a + d;
        e = (r <= TO) ? r : TO;
        if (r <= TO) begin
            exp_err = is_err;
            exp_rd  = (is_err || wr) ? IDLE : rdata;
        end else begin
            exp_err = 1'b1;
            exp_rd  = IDLE;
        end
        t_start         = $time;
        coreWriteEnable = wr;
        coreReadEnable  = rd;
        coreAddress     = addr;
        coreByteSelect  = sel;
        coreDataWrite   = wdata;
        wb_stall_i      = 1'b0;
        wb_ack_i        = 1'b0;
        wb_error_i      = 1'b0;
        #1;
        check("busy_on_request", {31'd0, coreBusy}, 32'd1);
        for (int c = 1; c <= e + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= e) begin
                check("cyc_active", {31'd0, wb_cyc_o}, 32'd1);
                check("stb", {31'd0, wb_stb_o}, (c <= ((a < e) ? a : e)) ? 32'd1 : 32'd0);
                check("busy_active", {31'd0, coreBusy}, 32'd1);
                check("rdata_pending", coreDataRead, IDLE);
                check("err_pending", {31'd0, coreError}, 32'd0);
                if (c == 1) begin
                    check("we", {31'd0, wb_we_o}, {31'd0, wr});
                    check("adr", {8'd0, wb_adr_o}, {8'd0, addr});
                    check("sel", {28'd0, wb_sel_o}, {28'd0, sel});
                    check("wdata_out", wb_data_o, wr ? wdata : 32'd0);
                end
                wb_stall_i = (c < a);
                wb_ack_i   = ((c == r) && !is_err) || (spur && (c < a));
                wb_error_i = (c == r) && is_err;
                wb_data_i  = (c == r) ? rdata : $urandom();
            end else begin
                check("cyc_finish", {31'd0, wb_cyc_o}, 32'd0);
                check("stb_finish", {31'd0, wb_stb_o}, 32'd0);
                check("busy_finish", {31'd0, coreBusy}, 32'd0);
                check("rdata_finish", coreDataRead, exp_rd);
                check("err_finish", {31'd0, coreError}, {31'd0, exp_err});
                wb_stall_i = 1'b0;
                wb_ack_i   = 1'b0;
                wb_error_i = 1'b0;
                if (!hold) begin
                    coreWriteEnable = 1'b0;
                    coreReadEnable  = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("cyc_after", {31'd0, wb_cyc_o}, 32'd0);
        check("stb_after", {31'd0, wb_stb_o}, 32'd0);
        if (hold) begin
            check("busy_held", {31'd0, coreBusy}, 32'd1);
        end else begin
            check("busy_idle", {31'd0, coreBusy}, 32'd0);
            check("rdata_idle", coreDataRead, IDLE);
            check("err_idle", {31'd0, coreError}, 32'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_we", {31'd0, wb_we_o}, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_adr", {8'd0, wb_adr_o}, 32'd0);
        check("rst_wdata", wb_data_o, 32'd0);
        check("rst_rdata", coreDataRead, IDLE);
        check("rst_err", {31'd0, coreError}, 32'd0);
        check("rst_busy", {31'd0, coreBusy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle-ack write
        access(1, 0, 24'h000040, 4'hF, 32'hDEADBEEF, 0, 1, 0, 32'h0, 0, 0);
        // Stalled read with late ack, with stray acks during the stall
        access(0, 1, 24'h800010, 4'hF, 32'h0, 3, 2, 0, 32'h12345678, 1, 0);
        // Read answered by bus error
        access(0, 1, 24'h000123, 4'h3, 32'h0, 0, 1, 1, 32'hA5A5A5A5, 0, 0);
        // Ack on the acceptance edge
        access(0, 1, 24'h00ABCD, 4'hC, 32'h0, 1, 0, 0, 32'hCAFEF00D, 0, 0);
        // No response: timeout, then stall forever: timeout
        access(0, 1, 24'h000200, 4'hF, 32'h0, 0, NEVER, 0, 32'h0, 0, 0);
        access(1, 0, 24'h000204, 4'h1, 32'h11223344, 20, NEVER, 0, 32'h0, 0, 0);
        // Ack on the timeout edge wins
        access(0, 1, 24'h000300, 4'hF, 32'h0, 0, 7, 0, 32'h87654321, 0, 0);
        // Both enables: write
        access(1, 1, 24'h000400, 4'h6, 32'h0BADF00D, 0, 1, 0, 32'h0, 0, 0);
        // Held request: back-to-back with 4-cycle spacing
        access(1, 0, 24'h000500, 4'hF, 32'h01020304, 0, 1, 0, 32'h0, 0, 1);
        t_first = t_start;
        access(1, 0, 24'h000500, 4'hF, 32'h01020304, 0, 1, 0, 32'h0, 0, 0);
        check("b2b_spacing", 32'(t_start - t_first), 32'd40);

        // Randomized accesses
        for (int i = 0; i < 30; i++) begin
            bit wr;
            bit rd;
            wr = 1'($urandom_range(0, 1));
            rd = !wr || (1'($urandom_range(0, 1)));
            access(wr, rd, 24'($urandom()), 4'($urandom()), $urandom(),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                   ($urandom_range(0, 4) == 0), $urandom(),
                   1'($urandom_range(0, 1)), 0);
        end

        // Asynchronous reset in WAIT_ACK
        coreReadEnable = 1'b1;
        coreAddress    = 24'h000600;
        coreByteSelect = 4'hF;
        @(posedge clk);
        @(negedge clk);
        wb_stall_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_cyc", {31'd0, wb_cyc_o}, 32'd1);
        check("pre_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("async_rst_stb", {31'd0, wb_stb_o}, 32'd0);
        wb_ack_i       = 1'b1;
        wb_data_i      = 32'h55AA55AA;
        coreReadEnable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("late_ack_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("late_ack_busy", {31'd0, coreBusy}, 32'd0);
        check("late_ack_rdata", coreDataRead, IDLE);
        check("late_ack_err", {31'd0, coreError}, 32'd0);
        wb_ack_i = 1'b0;
        @(negedge clk);
        // Recovery after reset
        access(0, 1, 24'h000700, 4'hF, 32'h0, 1, 1, 0, 32'h0F0F0F0F, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
